ctrl_bist_checker: RTL and testbench

- Self-test harness block for the 7-input / 26-output `ctrl` control benchmark.
- Drives all 2^PI_W input patterns into the DUT in ascending order on `pi_out`.
- Compacts each returned `po` vector into a multiple-input signature register (MISR) and compares the final signature with a golden value.
- Sits beside the DUT in silicon/FPGA regression, replacing exhaustive simulation print-out with a single pass/fail.

---
 rtl/ctrl_bist_pkg.sv | 24 ++
 rtl/ctrl_bist_checker_if.sv | 28 ++
 rtl/ctrl_bist_misr.sv | 47 ++++
 rtl/ctrl_bist_checker.sv | 140 ++++++++++++++
 tb/tb_ctrl_bist_checker.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_bist_pkg.sv
// Shared types, default sizing and the MISR step function for the ctrl BIST checker.
package ctrl_bist_pkg;

   localparam int              PI_W_DEF = 7;
   localparam int              PO_W_DEF = 26;
   // x^26 + x^6 + x^2 + x + 1: bit i set means feedback into bit i.
   localparam logic [PO_W_DEF-1:0] POLY_DEF = 26'h0000047;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_CMP,
      ST_DONE
   } state_e;

   // One MISR compaction step: shift left, fold the outgoing MSB back through
   // the taps, then xor in the new response.
   function automatic logic [PO_W_DEF-1:0] misr_next(input logic [PO_W_DEF-1:0] sig,
                                                     input logic [PO_W_DEF-1:0] din);
      return {sig[PO_W_DEF-2:0], 1'b0} ^ (sig[PO_W_DEF-1] ? POLY_DEF : '0) ^ din;
   endfunction

endpackage

// File: rtl/ctrl_bist_checker_if.sv
// Bundle between the BIST checker and its environment: control, golden value,
// DUT pattern/response pair and result reporting.
interface ctrl_bist_checker_if #(
   parameter int PI_W = 7,
   parameter int PO_W = 26
);
   logic            start;
   logic [PO_W-1:0] golden_sig;
   logic [PI_W-1:0] pi_out;
   logic [PO_W-1:0] po_in;
   logic            busy;
   logic            done;
   logic            pass;
   logic [PO_W-1:0] signature;
   logic [PI_W:0]   vec_cnt;

   // Environment side: requests runs and supplies the DUT response.
   modport master (
      output start, golden_sig, po_in,
      input  pi_out, busy, done, pass, signature, vec_cnt
   );

   // Checker side.
   modport slave (
      input  start, golden_sig, po_in,
      output pi_out, busy, done, pass, signature, vec_cnt
   );
endinterface

// File: rtl/ctrl_bist_misr.sv
// Multiple-input signature register: compacts one PO_W-bit response per enabled cycle.
module ctrl_bist_misr
   import ctrl_bist_pkg::*;
#(
   parameter int              PO_W = PO_W_DEF,
   parameter logic [PO_W-1:0] POLY = POLY_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            en,
   input  logic [PO_W-1:0] din,
   output logic [PO_W-1:0] sig
);

   logic [PO_W-1:0] sig_q, sig_d, step;

   // The package step function is fixed to the default geometry; any other
   // width/polynomial falls back to the same expression written generically.
   if (PO_W == PO_W_DEF && POLY == POLY_DEF) begin : g_pkg_step
      always_comb step = misr_next(sig_q, din);
   end else begin : g_gen_step
      always_comb step = {sig_q[PO_W-2:0], 1'b0} ^ (sig_q[PO_W-1] ? POLY : '0) ^ din;
   end

   // Next signature: clear wins, otherwise compact when enabled, otherwise hold.
   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = step;
      end
   end

   // Signature register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/ctrl_bist_checker.sv
// Exhaustive-pattern BIST checker for the ctrl benchmark: sweeps every input
// pattern, compacts the responses in a MISR and compares against a golden value.
module ctrl_bist_checker
   import ctrl_bist_pkg::*;
#(
   parameter int              PI_W    = PI_W_DEF,
   parameter int              PO_W    = PO_W_DEF,
   parameter int              DUT_LAT = 0,
   parameter logic [PO_W-1:0] POLY    = POLY_DEF
) (
   input logic                clk,
   input logic                rst_n,
   ctrl_bist_checker_if.slave bus
);

   localparam int              DRN_W    = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
   localparam logic [PI_W-1:0]  PAT_LAST = '1;

   state_e            state_q, state_d;
   logic [PI_W-1:0]   pat_q, pat_d;
   logic [DRN_W-1:0]  drn_q, drn_d;
   logic [PO_W-1:0]   gold_q, gold_d;
   logic [PI_W:0]     vec_q, vec_d;
   logic              pass_q, pass_d;
   logic              issue;
   logic              cap_en;
   logic              misr_clear;
   logic [PO_W-1:0]   sig;

   assign issue = (state_q == ST_RUN);

   // Issue-valid delay line: a response is captured exactly DUT_LAT cycles
   // after its pattern was driven, so stale pipeline contents are never compacted.
   if (DUT_LAT > 0) begin : g_dly
      logic [DUT_LAT-1:0] vld_q, vld_d;

      always_comb vld_d = (vld_q << 1) | DUT_LAT'(issue);

      // Delay-line register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
         end else begin
            vld_q <= vld_d;
         end
      end

      assign cap_en = vld_q[DUT_LAT-1];
   end else begin : g_no_dly
      assign cap_en = issue;
   end

   // FSM next state plus counter, golden and pass updates.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d    = state_q;
      pat_d      = pat_q;
      drn_d      = drn_q;
      gold_d     = gold_q;
      vec_d      = vec_q;
      pass_d     = pass_q;
      misr_clear = 1'b0;

      if (cap_en) begin
         vec_d = vec_q + 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d    = ST_RUN;
               gold_d     = bus.golden_sig;
               pat_d      = '0;
               vec_d      = '0;
               pass_d     = 1'b0;
               misr_clear = 1'b1;
            end
         end
         ST_RUN: begin
            pat_d = pat_q + 1'b1;
            if (pat_q == PAT_LAST) begin
               drn_d   = '0;
               state_d = (DUT_LAT > 0) ? ST_DRAIN : ST_CMP;
            end
         end
         ST_DRAIN: begin
            drn_d = drn_q + 1'b1;
            if (drn_q == DRN_LAST) begin
               state_d = ST_CMP;
            end
         end
         ST_CMP: begin
            pass_d  = (sig == gold_q);
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and bookkeeping registers; reset aborts any run outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         drn_q   <= '0;
         gold_q  <= '0;
         vec_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         state_q <= state_d;
         pat_q   <= pat_d;
         drn_q   <= drn_d;
         gold_q  <= gold_d;
         vec_q   <= vec_d;
         pass_q  <= pass_d;
      end
   end

   ctrl_bist_misr #(
      .PO_W (PO_W),
      .POLY (POLY)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (misr_clear),
      .en    (cap_en),
      .din   (bus.po_in),
      .sig   (sig)
   );

   assign bus.pi_out    = issue ? pat_q : '0;
   assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_CMP);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.pass      = pass_q;
   assign bus.signature = sig;
   assign bus.vec_cnt   = vec_q;

endmodule

// File: tb/tb_ctrl_bist_checker.sv
// Scoreboard bench for ctrl_bist_checker: a zero-latency and a two-cycle-latency
// instance driven with directed response patterns and hand-derived signatures.
module tb_ctrl_bist_checker;

   localparam int              PI_W = 7;
   localparam int              PO_W = 26;
   localparam logic [PO_W-1:0] TAPS = 26'h0000047;
   localparam logic [PO_W-1:0] JUNK = 26'h2AAAAAA;

   typedef struct {
      logic [PO_W-1:0] sig;
      logic            pass;
      logic [PI_W:0]   vec;
      int              lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   start_cyc0 = 0, start_cyc1 = 0;
   int   pi_err0 = 0, pi_err1 = 0;
   int   mode0 = 0;
   logic done0_prev = 1'b0, done1_prev = 1'b0;
   logic [PO_W-1:0] d1, d2;
   logic [PO_W-1:0] exp2;

   ctrl_bist_checker_if #(.PI_W(PI_W), .PO_W(PO_W)) if0 ();
   ctrl_bist_checker_if #(.PI_W(PI_W), .PO_W(PO_W)) if1 ();

   ctrl_bist_checker #(.PI_W(PI_W), .PO_W(PO_W), .DUT_LAT(0), .POLY(TAPS)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );

   ctrl_bist_checker #(.PI_W(PI_W), .PO_W(PO_W), .DUT_LAT(2), .POLY(TAPS)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   // Combinational stand-in DUT for instance 0, selected per run.
   always_comb begin
      case (mode0)
         1:       if0.po_in = (if0.pi_out == 7'd127) ? 26'h0000001 : '0;
         2:       if0.po_in = (if0.pi_out == 7'd126) ? 26'h0000001 : '0;
         3:       if0.po_in = (if0.pi_out == 7'd126) ? 26'h2000000 : '0;
         default: if0.po_in = '0;
      endcase
   end

   // Two-stage stand-in DUT for instance 1; junk is fed whenever no run is active
   // so a premature capture would corrupt the signature.
   always @(posedge clk) begin
      d1 <= if1.busy ? PO_W'(if1.pi_out) : JUNK;
      d2 <= d1;
   end
   assign if1.po_in = d2;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [PO_W-1:0] s, input logic p, input int v, input int l);
      exp_t e;
      e.sig  = s;
      e.pass = p;
      e.vec  = (PI_W+1)'(v);
      e.lat  = l;
      return e;
   endfunction

   // Bit-level reference of one compaction step.
   function automatic logic [PO_W-1:0] ref_step(input logic [PO_W-1:0] s, input logic [PO_W-1:0] d);
      logic [PO_W-1:0] r;
      r[0] = s[PO_W-1] ^ d[0];
      for (int i = 1; i < PO_W; i++) begin
         r[i] = s[i-1] ^ (TAPS[i] & s[PO_W-1]) ^ d[i];
      end
      return r;
   endfunction

   task automatic sb_compare(input string tag, input exp_t e, input logic [PO_W-1:0] sig,
                             input logic pass, input logic [PI_W:0] vec, input int lat,
                             input int pi_err);
      check({tag, "_signature"}, 64'(sig), 64'(e.sig));
      check({tag, "_pass"}, 64'(pass), 64'(e.pass));
      check({tag, "_vec_cnt"}, 64'(vec), 64'(e.vec));
      check({tag, "_done_latency"}, 64'(lat), 64'(e.lat));
      check({tag, "_pi_out_errors"}, 64'(pi_err), 64'd0);
   endtask

   // Monitor 0: track pi_out each cycle, score results when done rises.
   always @(negedge clk) begin
      automatic int   k = cyc - start_cyc0;
      automatic exp_t e;
      if (if0.busy) begin
         if (if0.pi_out != ((k < 128) ? PI_W'(k) : '0)) pi_err0++;
      end else if (if0.pi_out != '0) begin
         pi_err0++;
      end
      if (if0.done && !done0_prev) begin
         if (q0.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb0_unexpected_done: got done with empty queue, expected none");
         end else begin
            e = q0.pop_front();
            sb_compare("lat0", e, if0.signature, if0.pass, if0.vec_cnt, k, pi_err0);
         end
      end
      done0_prev <= if0.done;
   end

   // Monitor 1: same for the latency-2 instance.
   always @(negedge clk) begin
      automatic int   k = cyc - start_cyc1;
      automatic exp_t e;
      if (if1.busy) begin
         if (if1.pi_out != ((k < 128) ? PI_W'(k) : '0)) pi_err1++;
      end else if (if1.pi_out != '0) begin
         pi_err1++;
      end
      if (if1.done && !done1_prev) begin
         if (q1.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb1_unexpected_done: got done with empty queue, expected none");
         end else begin
            e = q1.pop_front();
            sb_compare("lat2", e, if1.signature, if1.pass, if1.vec_cnt, k, pi_err1);
         end
      end
      done1_prev <= if1.done;
   end

   task automatic start0(input logic [PO_W-1:0] g, input int m, input bit push, input exp_t e);
      @(negedge clk);
      mode0          = m;
      if0.golden_sig = g;
      if0.start      = 1'b1;
      if (push) q0.push_back(e);
      @(posedge clk);
      #1;
      if0.start  = 1'b0;
      start_cyc0 = cyc;
      pi_err0    = 0;
   endtask

   task automatic start1(input logic [PO_W-1:0] g, input exp_t e);
      @(negedge clk);
      if1.golden_sig = g;
      if1.start      = 1'b1;
      q1.push_back(e);
      @(posedge clk);
      #1;
      if1.start  = 1'b0;
      start_cyc1 = cyc;
      pi_err1    = 0;
   endtask

   task automatic wait_done0();
      int n = 0;
      while (!if0.done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("lat0_done_timeout", 64'(if0.done), 64'd1);
      @(negedge clk);
   endtask

   task automatic wait_done1();
      int n = 0;
      while (!if1.done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("lat2_done_timeout", 64'(if1.done), 64'd1);
      @(negedge clk);
   endtask

   initial begin
      if0.start      = 1'b0;
      if0.golden_sig = '0;
      if1.start      = 1'b0;
      if1.golden_sig = '0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs_lat0",
            64'({if0.busy, if0.done, if0.pass, if0.pi_out, if0.signature, if0.vec_cnt}), 64'd0);
      check("reset_outputs_lat2",
            64'({if1.busy, if1.done, if1.pass, if1.pi_out, if1.signature, if1.vec_cnt}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // All-zero responses, golden 0.
      start0(26'h0, 0, 1'b1, mk(26'h0, 1'b1, 128, 129));
      wait_done0();
      // Single 1 on the last pattern: matching and mismatching golden.
      start0(26'h1, 1, 1'b1, mk(26'h1, 1'b1, 128, 129));
      wait_done0();
      start0(26'h2, 1, 1'b1, mk(26'h1, 1'b0, 128, 129));
      wait_done0();
      // Single 1 one pattern earlier: shifted once.
      start0(26'h2, 2, 1'b1, mk(26'h2, 1'b1, 128, 129));
      wait_done0();
      // MSB one pattern before the end: shifted out through the taps.
      start0(26'h47, 3, 1'b1, mk(26'h47, 1'b1, 128, 129));
      wait_done0();

      // Back-to-back restart from DONE: results clear, identical outcome.
      start0(26'h47, 3, 1'b1, mk(26'h47, 1'b1, 128, 129));
      check("restart_done_pass", 64'({if0.done, if0.pass}), 64'd0);
      check("restart_signature", 64'(if0.signature), 64'd0);
      check("restart_vec_cnt", 64'(if0.vec_cnt), 64'd0);
      wait_done0();

      // start while busy is ignored, then reset aborts the run.
      start0(26'h0, 0, 1'b0, mk(26'h0, 1'b0, 0, 0));
      while (cyc - start_cyc0 < 39) @(negedge clk);
      if0.golden_sig = 26'h3FFFFFF;
      if0.start      = 1'b1;
      @(posedge clk);
      #1;
      if0.start = 1'b0;
      @(negedge clk);
      check("busy_start_vec_cnt", 64'(if0.vec_cnt), 64'd40);
      check("busy_start_pi_out", 64'(if0.pi_out), 64'd40);
      check("busy_start_busy", 64'(if0.busy), 64'd1);
      while (cyc - start_cyc0 < 59) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_reset_async",
            64'({if0.busy, if0.done, if0.pass, if0.pi_out, if0.signature, if0.vec_cnt}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrun_reset_idle",
            64'({if0.busy, if0.done, if0.pass, if0.pi_out, if0.signature, if0.vec_cnt}), 64'd0);
      start0(26'h123, 0, 1'b1, mk(26'h0, 1'b0, 128, 129));
      wait_done0();

      // Latency-2 instance: response is zero-extended pattern, two cycles late.
      exp2 = '0;
      for (int p = 0; p < 128; p++) exp2 = ref_step(exp2, PO_W'(p));
      start1(exp2, mk(exp2, 1'b1, 128, 131));
      wait_done1();

      check("sb0_drained", 64'(q0.size()), 64'd0);
      check("sb1_drained", 64'(q1.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
